lcd_display_ctrl: RTL

- HD44780-compatible 2x16 character LCD driver, 4-bit write-only interface. It consumes the 256-bit ASCII frame buffer (`strdata`) and the refresh strobe (`cls`) produced by the CPU debug top level.
- It drives LCDE/LCDRS/LCDRW/LCDDAT[3:0] directly.
- It performs the power-up init sequence, then redraws the full screen on each refresh request.

---
 rtl/lcd_display_ctrl_if.sv | 31 +++
 rtl/lcd_display_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display_ctrl_if.sv
// Host-side and LCD-pin signal bundle for the HD44780 4-bit driver.
// master = frame source / pin observer, slave = lcd_display_ctrl.
interface lcd_display_ctrl_if;
  logic         cls;
  logic [255:0] strdata;
  logic         busy;
  logic         rslcd;
  logic         rwlcd;
  logic         elcd;
  logic [3:0]   lcdd;

  modport master (
    output cls,
    output strdata,
    input  busy,
    input  rslcd,
    input  rwlcd,
    input  elcd,
    input  lcdd
  );

  modport slave (
    input  cls,
    input  strdata,
    output busy,
    output rslcd,
    output rwlcd,
    output elcd,
    output lcdd
  );
endinterface

// File: rtl/lcd_display_ctrl.sv
// HD44780 2x16 write-only 4-bit driver: power-up init, then full-screen redraw per refresh request.
//   top state | meaning                      xfer state | meaning
//   PWRUP     | power-up settle wait          X_IDLE     | launch next step
//   INIT      | 4 init nibbles + 4 commands   X_SETUP    | RS/data driven, E low
//   REFRESH   | 34 byte writes (2 rows)       X_EHI      | E high
//   IDLE      | waiting for cls / pending     X_GAP      | gap between nibbles
//                                             X_WAIT     | post-write settle
module lcd_display_ctrl #(
  parameter int PWRUP_CYC  = 750000,
  parameter int INIT1_CYC  = 205000,
  parameter int INIT2_CYC  = 5000,
  parameter int SETUP_CYC  = 2,
  parameter int EHI_CYC    = 12,
  parameter int NIBGAP_CYC = 50,
  parameter int CMD_CYC    = 2000,
  parameter int CLR_CYC    = 82000
) (
  input  logic           CCLK,
  input  logic           rst_n,
  lcd_display_ctrl_if.slave bus
);

  function automatic int cmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = cmax(cmax(cmax(PWRUP_CYC, INIT1_CYC), cmax(INIT2_CYC, SETUP_CYC)),
                             cmax(cmax(EHI_CYC, NIBGAP_CYC), cmax(CMD_CYC, CLR_CYC)));
  localparam int CW   = (MAXP < 2) ? 1 : $clog2(MAXP);

  // Down-counter load value: a wait of P cycles counts P-1 .. 0; zero behaves as one cycle.
  function automatic logic [CW-1:0] ld(input int p);
    return (p <= 1) ? '0 : CW'(p - 1);
  endfunction

  localparam logic [CW-1:0] L_PWRUP  = ld(PWRUP_CYC);
  localparam logic [CW-1:0] L_INIT1  = ld(INIT1_CYC);
  localparam logic [CW-1:0] L_INIT2  = ld(INIT2_CYC);
  localparam logic [CW-1:0] L_SETUP  = ld(SETUP_CYC);
  localparam logic [CW-1:0] L_EHI    = ld(EHI_CYC);
  localparam logic [CW-1:0] L_NIBGAP = ld(NIBGAP_CYC);
  localparam logic [CW-1:0] L_CMD    = ld(CMD_CYC);
  localparam logic [CW-1:0] L_CLR    = ld(CLR_CYC);

  localparam logic [1:0] T_PWRUP   = 2'd0;
  localparam logic [1:0] T_INIT    = 2'd1;
  localparam logic [1:0] T_REFRESH = 2'd2;
  localparam logic [1:0] T_IDLE    = 2'd3;

  localparam logic [2:0] X_IDLE  = 3'd0;
  localparam logic [2:0] X_SETUP = 3'd1;
  localparam logic [2:0] X_EHI   = 3'd2;
  localparam logic [2:0] X_GAP   = 3'd3;
  localparam logic [2:0] X_WAIT  = 3'd4;

  logic [1:0]    top_st;
  logic [2:0]    xf_st;
  logic [CW-1:0] cnt;
  logic [5:0]    step;
  logic          lo_phase;
  logic          pending;
  logic [255:0]  fb;
  logic          rs_q;
  logic          e_q;
  logic [3:0]    dat_q;

  logic          s_rs;
  logic          s_nib;
  logic [7:0]    s_data;
  logic [CW-1:0] s_wait;
  logic          s_last;
  logic [4:0]    char_idx;

  assign bus.rslcd = rs_q;
  assign bus.rwlcd = 1'b0;
  assign bus.elcd  = e_q;
  assign bus.lcdd  = dat_q;
  assign bus.busy  = (top_st != T_IDLE);

  // Decode of the current step: what to write, as nibble or byte, and how long to wait after.
  always_comb begin
    s_rs     = 1'b0;
    s_nib    = 1'b0;
    s_data   = 8'h00;
    s_wait   = L_CMD;
    s_last   = 1'b0;
    char_idx = 5'd0;
    if (top_st == T_INIT) begin
      s_last = (step == 6'd7);
      case (step[2:0])
        3'd0:    begin s_nib = 1'b1; s_data = 8'h03; s_wait = L_INIT1; end
        3'd1:    begin s_nib = 1'b1; s_data = 8'h03; s_wait = L_INIT2; end
        3'd2:    begin s_nib = 1'b1; s_data = 8'h03; end
        3'd3:    begin s_nib = 1'b1; s_data = 8'h02; end
        3'd4:    s_data = 8'h28;
        3'd5:    s_data = 8'h06;
        3'd6:    s_data = 8'h0C;
        default: begin s_data = 8'h01; s_wait = L_CLR; end
      endcase
    end else begin
      s_last = (step == 6'd33);
      if (step == 6'd0) begin
        s_data = 8'h80;
      end else if (step == 6'd17) begin
        s_data = 8'hC0;
      end else begin
        s_rs     = 1'b1;
        char_idx = (step < 6'd17) ? 5'(step - 6'd1) : 5'(step - 6'd2);
        s_data   = fb[{~char_idx, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      top_st   <= T_PWRUP;
      xf_st    <= X_IDLE;
      cnt      <= L_PWRUP;
      step     <= 6'd0;
      lo_phase <= 1'b0;
      pending  <= 1'b0;
      fb       <= '0;
      rs_q     <= 1'b0;
      e_q      <= 1'b0;
      dat_q    <= 4'h0;
    end else begin
      if (bus.cls && (top_st != T_IDLE))
        pending <= 1'b1;

      case (top_st)
        T_PWRUP: begin
          if (cnt == '0) begin
            top_st <= T_INIT;
            step   <= 6'd0;
            xf_st  <= X_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        T_IDLE: begin
          if (bus.cls || pending) begin
            top_st  <= T_REFRESH;
            fb      <= bus.strdata;
            pending <= 1'b0;
            step    <= 6'd0;
            xf_st   <= X_IDLE;
          end
        end

        default: begin
          case (xf_st)
            X_IDLE: begin
              rs_q     <= s_rs;
              dat_q    <= s_nib ? s_data[3:0] : s_data[7:4];
              lo_phase <= 1'b0;
              cnt      <= L_SETUP;
              xf_st    <= X_SETUP;
            end

            X_SETUP: begin
              if (cnt == '0) begin
                e_q   <= 1'b1;
                cnt   <= L_EHI;
                xf_st <= X_EHI;
              end else begin
                cnt <= cnt - CW'(1);
              end
            end

            X_EHI: begin
              if (cnt == '0) begin
                e_q <= 1'b0;
                if (!s_nib && !lo_phase) begin
                  cnt   <= L_NIBGAP;
                  xf_st <= X_GAP;
                end else begin
                  cnt   <= s_wait;
                  xf_st <= X_WAIT;
                end
              end else begin
                cnt <= cnt - CW'(1);
              end
            end

            X_GAP: begin
              if (cnt == '0) begin
                dat_q    <= s_data[3:0];
                lo_phase <= 1'b1;
                cnt      <= L_SETUP;
                xf_st    <= X_SETUP;
              end else begin
                cnt <= cnt - CW'(1);
              end
            end

            X_WAIT: begin
              if (cnt == '0) begin
                xf_st <= X_IDLE;
                if (!s_last) begin
                  step <= step + 6'd1;
                end else if (top_st == T_INIT) begin
                  // Post-init redraw is unconditional, so it leaves any queued request pending.
                  top_st <= T_REFRESH;
                  fb     <= bus.strdata;
                  step   <= 6'd0;
                end else if (pending || bus.cls) begin
                  fb      <= bus.strdata;
                  pending <= 1'b0;
                  step    <= 6'd0;
                end else begin
                  top_st <= T_IDLE;
                end
              end else begin
                cnt <= cnt - CW'(1);
              end
            end

            default: xf_st <= X_IDLE;
          endcase
        end
      endcase
    end
  end

endmodule
